// File: rtl/morphle_vec_driver.sv
// morphle_vec_driver: clocked initiator for an asynchronous Morphle Logic cell.
// Takes 7-bit test vectors {reset, in[1:0], match[1:0], expected[1:0]} over a
// valid/ready stream and drives each one into the cell with a four-phase
// return-to-empty handshake. The cell output is synchronized, sampled after a
// settle time and compared with the expected value. Results and counts are reported.
//
// Ports:
//   clk, reset_n              single clock, synchronous active-low reset
//   vec_valid/vec_ready       vector stream handshake
//   vec_data[6:0]             {reset, in[1:0], match[1:0], expected[1:0]}
//   cell_reset/in/match       registered drive to the cell
//   cell_out[1:0]             asynchronous cell output
//   res_valid                 one-cycle result strobe
//   res_out/err/timeout       sampled output, error and return-to-empty timeout
//   vec_count                 completed vectors (wraps)
//   err_count                 failing vectors (saturates)
module morphle_vec_driver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [6:0]       vec_data,
  output logic             cell_reset,
  output logic [1:0]       cell_in,
  output logic [1:0]       cell_match,
  input  logic [1:0]       cell_out,
  output logic             res_valid,
  output logic [1:0]       res_out,
  output logic             res_err,
  output logic             res_timeout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1,
    S_EMPTY = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]       out_s;

  logic             vec_ready_q, vec_ready_d;
  logic             cell_reset_q, cell_reset_d;
  logic [1:0]       cell_in_q, cell_in_d;
  logic [1:0]       cell_match_q, cell_match_d;
  logic [1:0]       exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_out_q, res_out_d;
  logic             res_err_q, res_err_d;
  logic             res_timeout_q, res_timeout_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             capture;
  logic             settle_hit;
  logic             timeout_hit;

  // Synchronizer for the asynchronous cell output; only out_s is used below.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cell_out};
    end
  end

  assign out_s = sync_q[SYNC_STAGES-1];

  assign capture     = (state_q == S_IDLE) && vec_valid && vec_ready_q;
  assign settle_hit  = (cnt_q == TW'(SETTLE - 1));
  assign timeout_hit = (cnt_q == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_VALID;
      S_VALID: if (settle_hit) state_d = S_EMPTY;
      S_EMPTY: if ((out_s == 2'b00) || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. The result is published on entry to DONE
  // so that res_valid, res_err and both counters change together.
  always_comb begin
    vec_ready_d   = (state_d == S_IDLE);
    cell_reset_d  = cell_reset_q;
    cell_in_d     = cell_in_q;
    cell_match_d  = cell_match_q;
    exp_d         = exp_q;
    mismatch_d    = mismatch_q;
    cnt_d         = cnt_q;
    res_valid_d   = 1'b0;
    res_out_d     = res_out_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    vec_count_d   = vec_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          cell_reset_d  = vec_data[6];
          cell_in_d     = vec_data[5:4];
          cell_match_d  = vec_data[3:2];
          exp_d         = vec_data[1:0];
          cnt_d         = '0;
          res_timeout_d = 1'b0;
        end
      end
      S_VALID: begin
        cnt_d = cnt_q + TW'(1);
        if (settle_hit) begin
          res_out_d    = out_s;
          mismatch_d   = (out_s != exp_q);
          cnt_d        = '0;
          // Return-to-empty: data and match go empty, reset keeps its value.
          cell_in_d    = 2'b00;
          cell_match_d = 2'b00;
        end
      end
      S_EMPTY: begin
        cnt_d = cnt_q + TW'(1);
        if ((out_s == 2'b00) || timeout_hit) begin
          res_valid_d   = 1'b1;
          res_timeout_d = (out_s != 2'b00);
          res_err_d     = mismatch_q | (out_s != 2'b00);
          vec_count_d   = vec_count_q + CNT_W'(1);
          if ((mismatch_q || (out_s != 2'b00)) && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vec_ready_q   <= 1'b1;
      cell_reset_q  <= 1'b1;
      cell_in_q     <= 2'b00;
      cell_match_q  <= 2'b00;
      exp_q         <= 2'b00;
      mismatch_q    <= 1'b0;
      cnt_q         <= '0;
      res_valid_q   <= 1'b0;
      res_out_q     <= 2'b00;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      vec_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      vec_ready_q   <= vec_ready_d;
      cell_reset_q  <= cell_reset_d;
      cell_in_q     <= cell_in_d;
      cell_match_q  <= cell_match_d;
      exp_q         <= exp_d;
      mismatch_q    <= mismatch_d;
      cnt_q         <= cnt_d;
      res_valid_q   <= res_valid_d;
      res_out_q     <= res_out_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      vec_count_q   <= vec_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign vec_ready   = vec_ready_q;
  assign cell_reset  = cell_reset_q;
  assign cell_in     = cell_in_q;
  assign cell_match  = cell_match_q;
  assign res_valid   = res_valid_q;
  assign res_out     = res_out_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_timeout_q;
  assign vec_count   = vec_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_morphle_vec_driver.sv
// tb_morphle_vec_driver: scoreboard bench for morphle_vec_driver with a
// behavioural Morphle cell (echo, fixed-01 and stuck-10 modes).
module tb_morphle_vec_driver;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 2;

  logic             clk;
  logic             reset_n;
  logic             vec_valid;
  logic             vec_ready;
  logic [6:0]       vec_data;
  logic             cell_reset;
  logic [1:0]       cell_in;
  logic [1:0]       cell_match;
  logic [1:0]       cell_out;
  logic             res_valid;
  logic [1:0]       res_out;
  logic             res_err;
  logic             res_timeout;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;

  morphle_vec_driver #(
    .SYNC_STAGES(2),
    .SETTLE     (SETTLE),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_data   (vec_data),
    .cell_reset (cell_reset),
    .cell_in    (cell_in),
    .cell_match (cell_match),
    .cell_out   (cell_out),
    .res_valid  (res_valid),
    .res_out    (res_out),
    .res_err    (res_err),
    .res_timeout(res_timeout),
    .vec_count  (vec_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell model: 0 = echo in while match is valid, 1 = answers 01 to any
  // non-empty in, 2 = stuck at 10.
  logic [1:0] mode;

  always_comb begin
    if (mode == 2'd2)           cell_out = 2'b10;
    else if (cell_reset)        cell_out = 2'b00;
    else if (mode == 2'd1)      cell_out = (cell_in == 2'b00) ? 2'b00 : 2'b01;
    else                        cell_out = (cell_match != 2'b00) ? cell_in : 2'b00;
  end

  typedef struct packed {
    logic [1:0]       out;
    logic             err;
    logic             tmo;
    logic [CNT_W-1:0] vc;
    logic [CNT_W-1:0] ec;
  } exp_t;

  exp_t             sb_q[$];
  int               n_tests;
  int               n_fail;
  int               n_resv;
  logic [CNT_W-1:0] m_vc;
  logic [CNT_W-1:0] m_ec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected result of one vector against the current cell mode.
  task automatic push_exp(input logic [6:0] v);
    exp_t       e;
    logic [1:0] s;
    if (mode == 2'd2)       s = 2'b10;
    else if (v[6])          s = 2'b00;
    else if (mode == 2'd1)  s = (v[5:4] == 2'b00) ? 2'b00 : 2'b01;
    else                    s = (v[3:2] != 2'b00) ? v[5:4] : 2'b00;
    e.out = s;
    e.tmo = (mode == 2'd2);
    e.err = (s != v[1:0]) || e.tmo;
    m_vc  = m_vc + 1'b1;
    if (e.err && (m_ec != {CNT_W{1'b1}})) m_ec = m_ec + 1'b1;
    e.vc  = m_vc;
    e.ec  = m_ec;
    sb_q.push_back(e);
  endtask

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && res_valid) begin
      n_resv++;
      if (sb_q.size() == 0) begin
        check_eq("res_valid_unexpected", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("res_out",     32'(res_out),     32'(e.out));
        check_eq("res_err",     32'(res_err),     32'(e.err));
        check_eq("res_timeout", 32'(res_timeout), 32'(e.tmo));
        check_eq("vec_count",   32'(vec_count),   32'(e.vc));
        check_eq("err_count",   32'(err_count),   32'(e.ec));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cell_reset"}, 32'(cell_reset), 32'd1);
    check_eq({tag, "_cell_in"},    32'(cell_in),    32'd0);
    check_eq({tag, "_cell_match"}, 32'(cell_match), 32'd0);
    check_eq({tag, "_res_valid"},  32'(res_valid),  32'd0);
    check_eq({tag, "_res_out"},    32'(res_out),    32'd0);
    check_eq({tag, "_res_err"},    32'(res_err),    32'd0);
    check_eq({tag, "_res_tmo"},    32'(res_timeout), 32'd0);
    check_eq({tag, "_vec_count"},  32'(vec_count),  32'd0);
    check_eq({tag, "_err_count"},  32'(err_count),  32'd0);
    check_eq({tag, "_vec_ready"},  32'(vec_ready),  32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    vec_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset_n = 1'b1;
    sb_q.delete();
    m_vc = '0;
    m_ec = '0;
  endtask

  // Handshake one vector; returns at the negedge after the accepting edge.
  task automatic send(input logic [6:0] v);
    int n;
    @(negedge clk);
    vec_data  = v;
    vec_valid = 1'b1;
    n = 0;
    while (!vec_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!vec_ready) check_eq("ready_wait", 32'(vec_ready), 32'd1);
    push_exp(v);
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    vec_data  = 7'($urandom);
  endtask

  // Counts clock edges from the accepting edge to the res_valid cycle.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!res_valid) check_eq("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  int lat;
  int caps;
  int last_cap;
  int cyc;
  int resv0;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_resv    = 0;
    m_vc      = '0;
    m_ec      = '0;
    mode      = 2'd0;
    reset_n   = 1'b0;
    vec_valid = 1'b0;
    vec_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("init");
    reset_n = 1'b1;

    // Reset vector: EMPTY exits in its first cycle.
    send(7'b1_00_00_00);
    wait_res(lat);
    check_eq("rstvec_latency", 32'(lat), 32'(SETTLE + 1));

    // Echo vector.
    send(7'b0_10_01_10);
    wait_res(lat);
    check_eq("echo_no_timeout", 32'(lat < SETTLE + TIMEOUT), 32'd1);
    check_eq("echo_vec_count", 32'(vec_count), 32'd2);
    check_eq("echo_err_count", 32'(err_count), 32'd0);

    // Mismatch: cell answers 01 where 10 is expected.
    mode = 2'd1;
    send(7'b0_01_01_10);
    wait_res(lat);
    check_eq("mis_res_out", 32'(res_out), 32'd1);
    check_eq("mis_res_err", 32'(res_err), 32'd1);
    mode = 2'd0;

    // Stuck cell: exactly TIMEOUT cycles in EMPTY.
    mode = 2'd2;
    send(7'b0_10_01_10);
    wait_res(lat);
    check_eq("tmo_latency", 32'(lat), 32'(SETTLE + TIMEOUT));
    mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check_eq("tmo_ready_after", 32'(vec_ready), 32'd1);
    check_eq("tmo_hold", 32'(res_timeout), 32'd1);
    check_eq("tmo_strobe_one_cycle", 32'(res_valid), 32'd0);

    // Next capture clears res_timeout; then reset in the middle of VALID.
    send(7'b0_10_01_10);
    check_eq("tmo_cleared_on_capture", 32'(res_timeout), 32'd0);
    check_eq("valid_drive_in", 32'(cell_in), 32'd2);
    do_reset();
    repeat (SETTLE + TIMEOUT + 10) @(negedge clk);

    // A vector after the aborted one completes normally.
    send(7'b0_10_01_10);
    wait_res(lat);
    check_eq("post_rst_vec_count", 32'(vec_count), 32'd1);

    // Saturating err_count while vec_count wraps.
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      send(7'b0_01_01_10);
      wait_res(lat);
    end
    mode = 2'd0;
    check_eq("sat_err_count", 32'(err_count), 32'd3);
    check_eq("wrap_vec_count", 32'(vec_count), 32'd0);

    // vec_valid held high across three vectors.
    @(negedge clk);
    vec_data  = 7'b0_10_01_10;
    vec_valid = 1'b1;
    caps      = 0;
    last_cap  = -1;
    cyc       = 0;
    resv0     = n_resv;
    while (caps < 3 && cyc < 500) begin
      if (vec_ready) begin
        push_exp(vec_data);
        if (last_cap >= 0) check_eq("b2b_spacing", 32'((cyc - last_cap) >= SETTLE + 3), 32'd1);
        last_cap = cyc;
        caps++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    vec_valid = 1'b0;
    check_eq("b2b_captures", 32'(caps), 32'd3);
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    check_eq("b2b_res_pulses", 32'(n_resv - resv0), 32'd3);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
